// File: rtl/victim_cache_ctrl_pkg.sv
// Shared line geometry, FSM state encoding and per-entry metadata for the
// victim cache controller.
package victim_cache_pkg;
    localparam int VICTIM_NO_OF_SETS = 4;
    localparam int DCACHE_LINE_WIDTH = 128;
    localparam int DCACHE_TAG_BITS   = 20;
    localparam int VICTIM_IDX_BITS   = $clog2(VICTIM_NO_OF_SETS);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_MEM_RD, S_EVICT, S_WB, S_VWRITE, S_RESP
    } vc_state_e;

    typedef struct packed {
        logic                       valid;
        logic                       dirty;
        logic [DCACHE_TAG_BITS-1:0] tag;
    } vc_meta_t;
endpackage

// File: rtl/victim_cache_ctrl_slot_select.sv
// Combinational priority encoders: lookup hit index and the insertion slot
// (in-place tag match, else lowest free entry, else the FIFO pointer).
module victim_slot_select
    import victim_cache_pkg::*;
(
    input  vc_meta_t [VICTIM_NO_OF_SETS-1:0] meta,
    input  logic [DCACHE_TAG_BITS-1:0]       lookup_tag,
    input  logic [DCACHE_TAG_BITS-1:0]       evict_tag,
    input  logic [VICTIM_IDX_BITS-1:0]       fifo_ptr,
    output logic                             hit,
    output logic [VICTIM_IDX_BITS-1:0]       hit_idx,
    output logic [VICTIM_IDX_BITS-1:0]       sel_idx,
    output logic                             sel_fifo
);
    logic                       match, free;
    logic [VICTIM_IDX_BITS-1:0] match_idx, free_idx;

    always_comb begin
        hit       = 1'b0;
        hit_idx   = '0;
        match     = 1'b0;
        match_idx = '0;
        free      = 1'b0;
        free_idx  = '0;
        // Scan downwards so the lowest qualifying index is the last one written.
        for (int i = VICTIM_NO_OF_SETS - 1; i >= 0; i--) begin
            if (meta[i].valid && meta[i].tag == lookup_tag) begin
                hit     = 1'b1;
                hit_idx = VICTIM_IDX_BITS'(i);
            end
            if (meta[i].valid && meta[i].tag == evict_tag) begin
                match     = 1'b1;
                match_idx = VICTIM_IDX_BITS'(i);
            end
            if (!meta[i].valid) begin
                free     = 1'b1;
                free_idx = VICTIM_IDX_BITS'(i);
            end
        end
        sel_fifo = !match && !free;
        sel_idx  = match ? match_idx : (free ? free_idx : fifo_ptr);
    end
endmodule

// File: rtl/victim_cache_ctrl.sv
// Victim cache miss-path sequencer: lookup/swap, memory refill, dirty victim
// write-back and insertion into the indexed 4-entry victim storage.
module victim_cache_ctrl
    import victim_cache_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         miss_req_i,
    input  logic [DCACHE_TAG_BITS-1:0]   miss_tag_i,
    input  logic                         evict_valid_i,
    input  logic                         evict_dirty_i,
    input  logic [DCACHE_TAG_BITS-1:0]   evict_tag_i,
    input  logic [DCACHE_LINE_WIDTH-1:0] evict_data_i,
    output logic                         miss_ack_o,
    output logic [DCACHE_LINE_WIDTH-1:0] fill_data_o,
    output logic [DCACHE_TAG_BITS-1:0]   fill_tag_o,
    output logic                         fill_dirty_o,
    output logic                         fill_from_victim_o,
    output logic [VICTIM_IDX_BITS-1:0]   vc_rd_idx_o,
    input  logic [DCACHE_LINE_WIDTH-1:0] vc_rd_data_i,
    output logic                         vc_write_o,
    output logic [VICTIM_IDX_BITS-1:0]   vc_wr_idx_o,
    output logic [DCACHE_LINE_WIDTH-1:0] vc_wr_data_o,
    output logic                         mem_rd_req_o,
    output logic [DCACHE_TAG_BITS-1:0]   mem_rd_tag_o,
    input  logic                         mem_rd_ack_i,
    input  logic [DCACHE_LINE_WIDTH-1:0] mem_rd_data_i,
    output logic                         mem_wb_req_o,
    output logic [DCACHE_TAG_BITS-1:0]   mem_wb_tag_o,
    output logic [DCACHE_LINE_WIDTH-1:0] mem_wb_data_o,
    input  logic                         mem_wb_ack_i,
    output logic [CNT_WIDTH-1:0]         hit_cnt_o,
    output logic [CNT_WIDTH-1:0]         miss_cnt_o
);
    vc_state_e                          state;
    vc_meta_t [VICTIM_NO_OF_SETS-1:0]   meta;
    logic [VICTIM_IDX_BITS-1:0]         fifo_ptr, slot, hit_idx, sel_idx;
    logic                               slot_fifo, hit, sel_fifo;
    logic [DCACHE_TAG_BITS-1:0]         miss_tag, ev_tag;
    logic                               ev_valid, ev_dirty;
    logic [DCACHE_LINE_WIDTH-1:0]       ev_data;
    logic [CNT_WIDTH-1:0]               hit_cnt, miss_cnt;

    victim_slot_select u_sel (
        .meta       (meta),
        .lookup_tag (miss_tag),
        .evict_tag  (ev_tag),
        .fifo_ptr   (fifo_ptr),
        .hit        (hit),
        .hit_idx    (hit_idx),
        .sel_idx    (sel_idx),
        .sel_fifo   (sel_fifo)
    );

    // Request/strobe outputs are decoded straight from the state register.
    assign miss_ack_o    = (state == S_RESP);
    assign mem_rd_req_o  = (state == S_MEM_RD);
    assign mem_wb_req_o  = (state == S_WB);
    assign vc_write_o    = (state == S_VWRITE);
    assign vc_rd_idx_o   = (state == S_LOOKUP) ? hit_idx : slot;
    assign vc_wr_idx_o   = slot;
    assign vc_wr_data_o  = ev_data;
    assign mem_rd_tag_o  = miss_tag;
    assign mem_wb_tag_o  = meta[slot].tag;
    assign mem_wb_data_o = (state == S_WB) ? vc_rd_data_i : '0;
    assign hit_cnt_o     = hit_cnt;
    assign miss_cnt_o    = miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_IDLE;
            meta               <= '0;
            fifo_ptr           <= '0;
            slot               <= '0;
            slot_fifo          <= 1'b0;
            miss_tag           <= '0;
            ev_valid           <= 1'b0;
            ev_dirty           <= 1'b0;
            ev_tag             <= '0;
            ev_data            <= '0;
            hit_cnt            <= '0;
            miss_cnt           <= '0;
            fill_data_o        <= '0;
            fill_tag_o         <= '0;
            fill_dirty_o       <= 1'b0;
            fill_from_victim_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (miss_req_i) begin
                    miss_tag <= miss_tag_i;
                    ev_valid <= evict_valid_i;
                    ev_dirty <= evict_dirty_i;
                    ev_tag   <= evict_tag_i;
                    ev_data  <= evict_data_i;
                    state    <= S_LOOKUP;
                end
                S_LOOKUP: begin
                    fill_tag_o <= miss_tag;
                    if (hit) begin
                        // Swap: line moves back to the dcache, entry is freed.
                        fill_data_o          <= vc_rd_data_i;
                        fill_dirty_o         <= meta[hit_idx].dirty;
                        fill_from_victim_o   <= 1'b1;
                        meta[hit_idx].valid  <= 1'b0;
                        if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_WIDTH'(1);
                        state                <= S_EVICT;
                    end else begin
                        fill_from_victim_o <= 1'b0;
                        if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_WIDTH'(1);
                        state              <= S_MEM_RD;
                    end
                end
                S_MEM_RD: if (mem_rd_ack_i) begin
                    fill_data_o  <= mem_rd_data_i;
                    fill_dirty_o <= 1'b0;
                    state        <= S_EVICT;
                end
                S_EVICT: begin
                    if (!ev_valid) begin
                        state <= S_RESP;
                    end else begin
                        slot      <= sel_idx;
                        slot_fifo <= sel_fifo;
                        // Only a FIFO pick can land on a valid entry needing write-back.
                        state     <= (sel_fifo && meta[sel_idx].dirty) ? S_WB : S_VWRITE;
                    end
                end
                S_WB: if (mem_wb_ack_i) state <= S_VWRITE;
                S_VWRITE: begin
                    meta[slot] <= '{valid: 1'b1, dirty: ev_dirty, tag: ev_tag};
                    if (slot_fifo) fifo_ptr <= fifo_ptr + VICTIM_IDX_BITS'(1);
                    state <= S_RESP;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Directed transaction table for victim_cache_ctrl plus reset-mid-refill sequence.
module tb_victim_cache_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         miss_req_i = 1'b0;
    logic [19:0]  miss_tag_i = '0;
    logic         evict_valid_i = 1'b0, evict_dirty_i = 1'b0;
    logic [19:0]  evict_tag_i = '0;
    logic [127:0] evict_data_i = '0;
    logic         miss_ack_o, fill_dirty_o, fill_from_victim_o;
    logic [127:0] fill_data_o;
    logic [19:0]  fill_tag_o;
    logic [1:0]   vc_rd_idx_o, vc_wr_idx_o;
    logic [127:0] vc_rd_data_i, vc_wr_data_o;
    logic         vc_write_o;
    logic         mem_rd_req_o, mem_rd_ack_i = 1'b0;
    logic [19:0]  mem_rd_tag_o;
    logic [127:0] mem_rd_data_i = '0;
    logic         mem_wb_req_o, mem_wb_ack_i = 1'b0;
    logic [19:0]  mem_wb_tag_o;
    logic [127:0] mem_wb_data_o;
    logic [1:0]   hit_cnt_o, miss_cnt_o;

    logic [127:0] store [4];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    victim_cache_ctrl #(.CNT_WIDTH(2)) dut (
        .clk(clk), .rst(rst),
        .miss_req_i(miss_req_i), .miss_tag_i(miss_tag_i),
        .evict_valid_i(evict_valid_i), .evict_dirty_i(evict_dirty_i),
        .evict_tag_i(evict_tag_i), .evict_data_i(evict_data_i),
        .miss_ack_o(miss_ack_o), .fill_data_o(fill_data_o), .fill_tag_o(fill_tag_o),
        .fill_dirty_o(fill_dirty_o), .fill_from_victim_o(fill_from_victim_o),
        .vc_rd_idx_o(vc_rd_idx_o), .vc_rd_data_i(vc_rd_data_i),
        .vc_write_o(vc_write_o), .vc_wr_idx_o(vc_wr_idx_o), .vc_wr_data_o(vc_wr_data_o),
        .mem_rd_req_o(mem_rd_req_o), .mem_rd_tag_o(mem_rd_tag_o),
        .mem_rd_ack_i(mem_rd_ack_i), .mem_rd_data_i(mem_rd_data_i),
        .mem_wb_req_o(mem_wb_req_o), .mem_wb_tag_o(mem_wb_tag_o),
        .mem_wb_data_o(mem_wb_data_o), .mem_wb_ack_i(mem_wb_ack_i),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    // Victim storage: indexed RAM with combinational read.
    assign vc_rd_data_i = store[vc_rd_idx_o];
    always @(posedge clk) if (vc_write_o) store[vc_wr_idx_o] <= vc_wr_data_o;

    typedef struct {
        logic [19:0]  miss_tag;
        logic         ev_valid, ev_dirty;
        logic [19:0]  ev_tag;
        logic [11:0]  ev_salt;
        int           rd_lat, wb_lat;
        logic         victim, dirty;
        logic [127:0] fill;
        logic [19:0]  wb_tag;
        logic [127:0] wb_data;
        logic [1:0]   wr_idx;
        int           lat, hits, misses;
    } vec_t;

    vec_t tbl [14];

    function automatic logic [127:0] line(input logic [19:0] t, input logic [11:0] s);
        return {t, s, t, s, t, s, t, s};
    endfunction

    function automatic vec_t mk(input logic [19:0] mt, input logic ev, input logic ed,
                                input logic [19:0] et, input logic [11:0] es, input int rl,
                                input int wl, input logic vic, input logic fd,
                                input logic [127:0] fill, input logic [19:0] wt,
                                input logic [127:0] wd, input logic [1:0] wi, input int lat,
                                input int h, input int m);
        vec_t v;
        v.miss_tag = mt; v.ev_valid = ev; v.ev_dirty = ed; v.ev_tag = et; v.ev_salt = es;
        v.rd_lat = rl; v.wb_lat = wl; v.victim = vic; v.dirty = fd; v.fill = fill;
        v.wb_tag = wt; v.wb_data = wd; v.wr_idx = wi; v.lat = lat; v.hits = h; v.misses = m;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input int n, input vec_t v);
        int cyc = 0, rd_cyc = 0, wb_cyc = 0, wr_cnt = 0, wr_in_wb = 0;
        bit done = 0, wb_pend = 0;
        logic [19:0]  rd_tag = '0, wb_tag = '0;
        logic [127:0] wb_data = '0, wr_data = '0, f_data = '0;
        logic [19:0]  f_tag = '0;
        logic [1:0]   wr_idx = '0, hc = '0, mc = '0;
        logic         f_dirty = 1'b0, f_vic = 1'b0;
        @(negedge clk);
        miss_req_i = 1'b1; miss_tag_i = v.miss_tag;
        evict_valid_i = v.ev_valid; evict_dirty_i = v.ev_dirty; evict_tag_i = v.ev_tag;
        evict_data_i = line(v.ev_tag, v.ev_salt);
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            mem_rd_ack_i = 1'b0;
            mem_wb_ack_i = 1'b0;
            if (vc_write_o) begin
                wr_cnt++; wr_idx = vc_wr_idx_o; wr_data = vc_wr_data_o;
                if (wb_pend || mem_wb_req_o) wr_in_wb++;
            end
            if (mem_rd_req_o) begin
                rd_cyc++; rd_tag = mem_rd_tag_o;
                if (rd_cyc == v.rd_lat) begin
                    mem_rd_ack_i = 1'b1; mem_rd_data_i = line(mem_rd_tag_o, 12'hF00);
                end
            end
            if (mem_wb_req_o) begin
                wb_cyc++; wb_tag = mem_wb_tag_o; wb_data = mem_wb_data_o;
                if (wb_cyc == v.wb_lat) begin mem_wb_ack_i = 1'b1; wb_pend = 0; end
                else wb_pend = 1;
            end
            if (miss_ack_o) begin
                done = 1;
                f_data = fill_data_o; f_tag = fill_tag_o; f_dirty = fill_dirty_o;
                f_vic = fill_from_victim_o; hc = hit_cnt_o; mc = miss_cnt_o;
            end
        end
        miss_req_i = 1'b0; evict_valid_i = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL t%0d timeout: no miss_ack_o within %0d cycles", n, cyc);
            return;
        end
        chk($sformatf("t%0d latency", n), cyc, v.lat);
        chk($sformatf("t%0d rd_cycles", n), rd_cyc, v.rd_lat);
        if (v.rd_lat > 0) chk($sformatf("t%0d rd_tag", n), rd_tag, v.miss_tag);
        chk($sformatf("t%0d wb_cycles", n), wb_cyc, v.wb_lat);
        if (v.wb_lat > 0) begin
            chk($sformatf("t%0d wb_tag", n), wb_tag, v.wb_tag);
            chk($sformatf("t%0d wb_data", n), wb_data, v.wb_data);
        end
        chk($sformatf("t%0d writes", n), wr_cnt, v.ev_valid ? 1 : 0);
        if (v.ev_valid) begin
            chk($sformatf("t%0d wr_idx", n), wr_idx, v.wr_idx);
            chk($sformatf("t%0d wr_data", n), wr_data, line(v.ev_tag, v.ev_salt));
        end
        chk($sformatf("t%0d write_during_wb", n), wr_in_wb, 0);
        chk($sformatf("t%0d fill_data", n), f_data, v.fill);
        chk($sformatf("t%0d fill_tag", n), f_tag, v.miss_tag);
        chk($sformatf("t%0d fill_dirty", n), f_dirty, v.dirty);
        chk($sformatf("t%0d from_victim", n), f_vic, v.victim);
        chk($sformatf("t%0d hit_cnt", n), hc, v.hits);
        chk($sformatf("t%0d miss_cnt", n), mc, v.misses);
        @(negedge clk);
        chk($sformatf("t%0d ack_pulse", n), miss_ack_o, 1'b0);
    endtask

    task automatic reset_mid_rd();
        int n = 0;
        @(negedge clk);
        miss_req_i = 1'b1; miss_tag_i = 20'h00777; evict_valid_i = 1'b0;
        while (!mem_rd_req_o && n < 10) begin @(negedge clk); n++; end
        chk("rst_reached_mem_rd", mem_rd_req_o, 1'b1);
        rst = 1'b1; miss_req_i = 1'b0;
        @(negedge clk);
        chk("rst_mem_rd_req", mem_rd_req_o, 1'b0);
        chk("rst_ack", miss_ack_o, 1'b0);
        chk("rst_hit_cnt", hit_cnt_o, 2'd0);
        chk("rst_miss_cnt", miss_cnt_o, 2'd0);
        chk("rst_from_victim", fill_from_victim_o, 1'b0);
        chk("rst_fill_data", fill_data_o, 128'd0);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) store[i] = '0;
        //          miss     ev dirty evtag    salt  rd wb vic fd fill                     wbtag    wbdata                 idx lat h m
        tbl[0]  = mk(20'hABC, 1, 0, 20'h123, 12'h001, 2, 0, 0, 0, line(20'hABC, 12'hF00), '0, '0, 0, 6, 0, 1);
        tbl[1]  = mk(20'h123, 1, 0, 20'h200, 12'h002, 0, 0, 1, 0, line(20'h123, 12'h001), '0, '0, 0, 4, 1, 1);
        tbl[2]  = mk(20'h200, 0, 0, 20'h000, 12'h000, 0, 0, 1, 0, line(20'h200, 12'h002), '0, '0, 0, 3, 2, 1);
        tbl[3]  = mk(20'h300, 1, 1, 20'h010, 12'h010, 1, 0, 0, 0, line(20'h300, 12'hF00), '0, '0, 0, 5, 2, 2);
        tbl[4]  = mk(20'h301, 1, 1, 20'h011, 12'h011, 3, 0, 0, 0, line(20'h301, 12'hF00), '0, '0, 1, 7, 2, 3);
        tbl[5]  = mk(20'h302, 1, 1, 20'h012, 12'h012, 1, 0, 0, 0, line(20'h302, 12'hF00), '0, '0, 2, 5, 2, 3);
        tbl[6]  = mk(20'h303, 1, 1, 20'h013, 12'h013, 1, 0, 0, 0, line(20'h303, 12'hF00), '0, '0, 3, 5, 2, 3);
        tbl[7]  = mk(20'h304, 1, 0, 20'h020, 12'h020, 1, 6, 0, 0, line(20'h304, 12'hF00),
                     20'h010, line(20'h010, 12'h010), 0, 11, 2, 3);
        tbl[8]  = mk(20'h305, 1, 0, 20'h012, 12'h112, 1, 0, 0, 0, line(20'h305, 12'hF00), '0, '0, 2, 5, 2, 3);
        tbl[9]  = mk(20'h306, 1, 1, 20'h021, 12'h021, 1, 2, 0, 0, line(20'h306, 12'hF00),
                     20'h011, line(20'h011, 12'h011), 1, 7, 2, 3);
        tbl[10] = mk(20'h012, 0, 0, 20'h000, 12'h000, 0, 0, 1, 0, line(20'h012, 12'h112), '0, '0, 0, 3, 3, 3);
        tbl[11] = mk(20'h013, 1, 0, 20'h040, 12'h040, 0, 0, 1, 1, line(20'h013, 12'h013), '0, '0, 2, 4, 3, 3);
        tbl[12] = mk(20'h021, 0, 0, 20'h000, 12'h000, 0, 0, 1, 1, line(20'h021, 12'h021), '0, '0, 0, 3, 3, 3);
        tbl[13] = mk(20'h020, 1, 0, 20'h050, 12'h050, 1, 0, 0, 0, line(20'h020, 12'hF00), '0, '0, 0, 5, 0, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_ack", miss_ack_o, 1'b0);
        chk("reset_rd_req", mem_rd_req_o, 1'b0);
        chk("reset_wb_req", mem_wb_req_o, 1'b0);
        chk("reset_write", vc_write_o, 1'b0);
        chk("reset_hit_cnt", hit_cnt_o, 2'd0);
        chk("reset_miss_cnt", miss_cnt_o, 2'd0);

        for (int i = 0; i < 14; i++) begin
            if (i == 13) reset_mid_rd();
            run_txn(i, tbl[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
